secure_encryption_controller: RTL



---
 rtl/secure_encryption_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/secure_encryption_controller.sv
// Round sequencer for the combinational secure_encryption_module datapath.
// Holds the key, drives per-round keys and zeroizes secret state after each block.
module secure_encryption_controller #(
  parameter int N      = 8,
  parameter int ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [N-1:0] key_in,
  input  logic         key_clear,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         busy,
  output logic [N-1:0] enc_data,
  output logic [N-1:0] enc_key,
  input  logic [N-1:0] enc_result
);

  localparam int RW = $clog2(ROUNDS) + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_OUTPUT = 2'd2,
    S_CLEAR  = 2'd3
  } fsm_t;

  fsm_t         fsm_r;
  logic [N-1:0] key_r;
  logic [N-1:0] blk_key_r;
  logic         key_valid_r;
  logic [N-1:0] state_r;
  logic [RW-1:0] round_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic [N-1:0] data_out_r;
  logic [N-1:0] enc_data_r;
  logic [N-1:0] enc_key_r;

  // Rotate left by (r mod N); a rotate by 0 returns k unchanged.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] k, input logic [RW-1:0] r);
    logic [2*N-1:0] dbl;
    int unsigned    sh;
    sh  = 32'(r) % N;
    dbl = {k, k} << sh;
    return dbl[2*N-1:N];
  endfunction

  // Control FSM; every output is a register updated alongside the state.
  // blk_key_r snapshots the key at accept so a key loaded in the same cycle
  // only takes effect from the following block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r       <= S_IDLE;
      key_r       <= '0;
      blk_key_r   <= '0;
      key_valid_r <= 1'b0;
      state_r     <= '0;
      round_r     <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      data_out_r  <= '0;
      enc_data_r  <= '0;
      enc_key_r   <= '0;
    end else if (key_clear) begin
      fsm_r       <= S_IDLE;
      key_r       <= '0;
      blk_key_r   <= '0;
      key_valid_r <= 1'b0;
      state_r     <= '0;
      round_r     <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      data_out_r  <= '0;
      enc_data_r  <= '0;
      enc_key_r   <= '0;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          if (key_load) begin
            key_r       <= key_in;
            key_valid_r <= 1'b1;
          end
          if (in_valid && in_ready_r) begin
            fsm_r      <= S_ROUND;
            state_r    <= data_in;
            round_r    <= '0;
            blk_key_r  <= key_r;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            enc_data_r <= data_in;
            enc_key_r  <= key_r;
          end else begin
            in_ready_r <= key_load | key_valid_r;
          end
        end
        S_ROUND: begin
          state_r <= enc_result;
          round_r <= round_r + RW'(1);
          if (round_r == LAST_ROUND) begin
            fsm_r       <= S_OUTPUT;
            out_valid_r <= 1'b1;
            data_out_r  <= enc_result;
            enc_data_r  <= '0;
            enc_key_r   <= '0;
          end else begin
            enc_data_r <= enc_result;
            enc_key_r  <= rotl(blk_key_r, round_r + RW'(1));
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            fsm_r       <= S_CLEAR;
            out_valid_r <= 1'b0;
            data_out_r  <= '0;
          end else begin
            data_out_r <= state_r;
          end
        end
        S_CLEAR: begin
          fsm_r      <= S_IDLE;
          state_r    <= '0;
          round_r    <= '0;
          blk_key_r  <= '0;
          busy_r     <= 1'b0;
          in_ready_r <= key_valid_r;
        end
        default: begin
          fsm_r       <= S_IDLE;
          state_r     <= '0;
          round_r     <= '0;
          blk_key_r   <= '0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          data_out_r  <= '0;
          enc_data_r  <= '0;
          enc_key_r   <= '0;
        end
      endcase
    end
  end

  assign key_valid = key_valid_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;
  assign enc_data  = enc_data_r;
  assign enc_key   = enc_key_r;

endmodule
